// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared state encoding and stage control bundle for the hazard sequencer
package RVS192_package;

  typedef enum logic [1:0] {
    HZ_RUN,
    HZ_MEM_WAIT,
    HZ_REDIR_PEND
  } hz_state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RUN    = 8'b11111_000;
  localparam pipe_ctrl_t CTRL_FREEZE = 8'b00000_000;

endpackage

// File: rtl/pipeline_hazard_ctrl_watchdog.sv
// rtl/pipeline_hazard_ctrl_watchdog.sv - saturating frozen-fetch counter with sticky timeout flag
module hazard_watchdog #(
  parameter int STALL_TIMEOUT = 1024,
  parameter int TO_W          = $clog2(STALL_TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pc_en_i,
  output logic stall_timeout_o
);

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(STALL_TIMEOUT);

  logic [TO_W-1:0] count_q, count_d;
  logic            flag_q;

  always_comb begin
    count_d = count_q;
    if (pc_en_i) begin
      count_d = '0;
    end else if (count_q != TO_MAX) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      if (count_d == TO_MAX) begin
        flag_q <= 1'b1;
      end
    end
  end

  assign stall_timeout_o = flag_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipe
// Optional per-event performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
  import RVS192_package::*;
#(
  parameter int XLEN          = 32,
  parameter int STALL_TIMEOUT = 1024,
  parameter int TO_W          = $clog2(STALL_TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fw_halt,
  input  logic            icache_stall,
  input  logic            dcache_stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            pc_en,
  output logic            if_id_en,
  output logic            id_ex_en,
  output logic            ex_mem_en,
  output logic            mem_wb_en,
  output logic            if_id_flush,
  output logic            id_ex_flush,
  output logic            ex_mem_flush,
  output logic            pc_redirect_valid,
  output logic [XLEN-1:0] pc_redirect_target,
  output logic            stall_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]     perf_dstall,
  output logic [31:0]     perf_istall,
  output logic [31:0]     perf_fwhalt,
  output logic [31:0]     perf_redir
`endif
);

  hz_state_e       state_q, state_d;
  logic            pend_q, pend_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  pipe_ctrl_t      ctrl;
  logic            redir_apply, fw_apply, ic_apply;

  always_comb begin
    state_d     = HZ_RUN;
    pend_d      = pend_q;
    tgt_d       = tgt_q;
    ctrl        = CTRL_RUN;
    redir_apply = 1'b0;
    fw_apply    = 1'b0;
    ic_apply    = 1'b0;
    if (dcache_stall) begin
      ctrl    = CTRL_FREEZE;
      state_d = HZ_MEM_WAIT;
      if (redirect_valid) begin
        pend_d = 1'b1;
        tgt_d  = redirect_target;
      end
    end else begin
      // A redirect held across a D-miss is released on the first unfrozen cycle.
      if (state_q == HZ_MEM_WAIT && pend_q) begin
        state_d     = HZ_REDIR_PEND;
        redir_apply = 1'b1;
      end
      if (redirect_valid) begin
        redir_apply = 1'b1;
      end
      if (redir_apply) begin
        pend_d           = 1'b0;
        ctrl.if_id_flush = 1'b1;
        ctrl.id_ex_flush = 1'b1;
      end else if (fw_halt) begin
        fw_apply          = 1'b1;
        ctrl.pc_en        = 1'b0;
        ctrl.if_id_en     = 1'b0;
        ctrl.id_ex_en     = 1'b0;
        ctrl.ex_mem_flush = 1'b1;
      end else if (icache_stall) begin
        ic_apply         = 1'b1;
        ctrl.pc_en       = 1'b0;
        ctrl.if_id_en    = 1'b0;
        ctrl.id_ex_flush = 1'b1;
      end
    end
    // Outputs are forced quiet while reset is held.
    if (!rst_n) begin
      ctrl        = CTRL_FREEZE;
      redir_apply = 1'b0;
      fw_apply    = 1'b0;
      ic_apply    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HZ_RUN;
      pend_q  <= 1'b0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      tgt_q   <= tgt_d;
    end
  end

  assign pc_en              = ctrl.pc_en;
  assign if_id_en           = ctrl.if_id_en;
  assign id_ex_en           = ctrl.id_ex_en;
  assign ex_mem_en          = ctrl.ex_mem_en;
  assign mem_wb_en          = ctrl.mem_wb_en;
  assign if_id_flush        = ctrl.if_id_flush;
  assign id_ex_flush        = ctrl.id_ex_flush;
  assign ex_mem_flush       = ctrl.ex_mem_flush;
  assign pc_redirect_valid  = redir_apply;
  assign pc_redirect_target = !rst_n ? '0 : (redirect_valid ? redirect_target : tgt_q);

  hazard_watchdog #(
    .STALL_TIMEOUT (STALL_TIMEOUT),
    .TO_W          (TO_W)
  ) u_wd (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_en_i         (ctrl.pc_en),
    .stall_timeout_o (stall_timeout)
  );

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] dstall_q, istall_q, fwhalt_q, redir_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dstall_q <= '0;
      istall_q <= '0;
      fwhalt_q <= '0;
      redir_q  <= '0;
    end else begin
      dstall_q <= dstall_q + {31'd0, dcache_stall};
      istall_q <= istall_q + {31'd0, ic_apply};
      fwhalt_q <= fwhalt_q + {31'd0, fw_apply};
      redir_q  <= redir_q + {31'd0, redir_apply};
    end
  end

  assign perf_dstall = dstall_q;
  assign perf_istall = istall_q;
  assign perf_fwhalt = fwhalt_q;
  assign perf_redir  = redir_q;
`endif

endmodule
